seq_pattern_gen: RTL and testbench



---
 rtl/seq_pattern_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: captures a parallel pattern on start and shifts it out MSB-first.
// Optional parity bit after each repetition is enabled by SEQ_PATTERN_GEN_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | out carries a pattern bit
// PAR   | out carries the repetition's even-parity bit (parity build only)
// GAP   | idle cycles between repetitions, busy still high
// DONE  | one-cycle completion pulse
module seq_pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_W   = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  input  logic               abort,
  output logic               out,
  output logic               out_valid,
  output logic               out_parity,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    S_PAR   = 3'd2,
`endif
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] sh_q, sh_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   bits_q, bits_d;
  logic [CNT_W-1:0]   reps_q, reps_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic               out_d, valid_d, busy_d, done_d;
  logic [LEN_W-1:0]   len_c, src_len;
  logic [MAX_LEN-1:0] pat_al, src;
  logic               rep_end, load_rep;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
  logic               par_q, par_d;
  logic               opar_q, opar_d;
`endif

  // Pattern is left-aligned at capture so the next bit is always the MSB of the shifter.
  assign len_c   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign pat_al  = pattern << (LEN_W'(MAX_LEN) - len_c);
  assign src     = (state_q == S_IDLE) ? pat_al : pat_q;
  assign src_len = (state_q == S_IDLE) ? len_c : len_q;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    sh_d     = sh_q;
    len_d    = len_q;
    bits_d   = bits_q;
    reps_d   = reps_q;
    gap_d    = gap_q;
    gcnt_d   = gcnt_q;
    out_d    = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    rep_end  = 1'b0;
    load_rep = 1'b0;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    par_d    = par_q;
    opar_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          pat_d  = pat_al;
          len_d  = len_c;
          gap_d  = gap;
          reps_d = (reps == '0) ? CNT_W'(1) : reps;
          if (len_c == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            load_rep = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (bits_q > LEN_W'(1)) begin
          bits_d  = bits_q - 1'b1;
          out_d   = sh_q[MAX_LEN-1];
          sh_d    = sh_q << 1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
          par_d   = par_q ^ sh_q[MAX_LEN-1];
`endif
        end else begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
          state_d = S_PAR;
          out_d   = par_q;
          valid_d = 1'b1;
          opar_d  = 1'b1;
          busy_d  = 1'b1;
`else
          rep_end = 1'b1;
`endif
        end
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      S_PAR: rep_end = 1'b1;
`endif
      S_GAP: begin
        if (gcnt_q > GAP_W'(1)) begin
          gcnt_d = gcnt_q - 1'b1;
          busy_d = 1'b1;
        end else begin
          load_rep = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (rep_end) begin
      if (reps_q > CNT_W'(1)) begin
        reps_d = reps_q - 1'b1;
        if (gap_q != '0) begin
          state_d = S_GAP;
          gcnt_d  = gap_q;
          busy_d  = 1'b1;
        end else begin
          load_rep = 1'b1;
        end
      end else begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    if (load_rep) begin
      state_d = S_SHIFT;
      out_d   = src[MAX_LEN-1];
      sh_d    = src << 1;
      bits_d  = src_len;
      valid_d = 1'b1;
      busy_d  = 1'b1;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      par_d   = src[MAX_LEN-1];
`endif
    end

    // Abort drops straight to IDLE with quiet outputs and no done pulse.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      out_d   = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      opar_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      sh_q      <= '0;
      len_q     <= '0;
      bits_q    <= '0;
      reps_q    <= '0;
      gap_q     <= '0;
      gcnt_q    <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      sh_q      <= sh_d;
      len_q     <= len_d;
      bits_q    <= bits_d;
      reps_q    <= reps_d;
      gap_q     <= gap_d;
      gcnt_q    <= gcnt_d;
      out       <= out_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

`ifdef SEQ_PATTERN_GEN_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q  <= 1'b0;
      opar_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      opar_q <= opar_d;
    end
  end
  assign out_parity = opar_q;
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: queue-based expected-output model plus directed runs
// with hand-computed literal expectations (parity figures follow SEQ_PATTERN_GEN_PARITY_EN).
module tb_seq_pattern_gen;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic [2:0] gap = '0;
  logic       out, out_valid, out_parity, busy, done;

  int          total = 0;
  int          bad = 0;
  logic [4:0]  q[$];
  int          run_id = 0;
  int          seen_id = 0;
  int          run_cyc = 0;
  int          nvalid = 0;
  int          done_at = 0;
  logic [31:0] vbits = '0;
  bit          done_seen = 1'b0;
  bit          chk_en = 1'b0;

`ifdef SEQ_PATTERN_GEN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  seq_pattern_gen #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4), .GAP_W(3)) dut (
    .clk(clk), .rstn(rstn), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .gap(gap), .abort(abort), .out(out), .out_valid(out_valid),
    .out_parity(out_parity), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected per-cycle {out, out_valid, out_parity, busy, done} for a whole run.
  task automatic build();
    int l;
    int r;
    bit p;
    l = (len > 4'd8) ? 8 : int'(len);
    r = (reps == 4'd0) ? 1 : int'(reps);
    if (l == 0) begin
      q.push_back(5'b00001);
      return;
    end
    for (int k = 0; k < r; k++) begin
      p = 1'b0;
      for (int i = l - 1; i >= 0; i--) begin
        q.push_back({pattern[i], 4'b1010});
        p ^= pattern[i];
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      q.push_back({p, 4'b1110});
`endif
      if (k < r - 1) repeat (int'(gap)) q.push_back(5'b00010);
    end
    q.push_back(5'b00001);
  endtask

  task automatic start_run(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                           input logic [2:0] g);
    @(negedge clk);
    pattern = p; len = l; reps = r; gap = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pattern = ~p; reps = 4'd7; gap = 3'd5;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(posedge clk);
    while (!done_seen && n < 200) begin
      @(posedge clk);
      n++;
    end
    check({name, "_timeout"}, {31'b0, done_seen}, 32'd1);
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) q.delete();
        else if (q.size() != 0) begin
          if (abort) q.delete();
          else void'(q.pop_front());
        end else if (start && !abort) begin
          build();
          run_id++;
        end
      end
      forever begin
        logic [4:0] exp;
        @(negedge clk);
        if (chk_en) begin
          if (run_id != seen_id) begin
            seen_id = run_id; run_cyc = 0; nvalid = 0; vbits = '0;
            done_seen = 1'b0; done_at = 0;
          end
          run_cyc++;
          exp = (q.size() != 0) ? q[0] : 5'b0;
          check("cycle", {27'b0, out, out_valid, out_parity, busy, done}, {27'b0, exp});
          if (out_valid) begin
            vbits = {vbits[30:0], out};
            nvalid++;
          end
          if (done) begin
            done_seen = 1'b1;
            done_at = run_cyc;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk_en = 1'b1;
    check("reset_outs", {27'b0, out, out_valid, out_parity, busy, done}, 32'd0);

    // Basic 1011 run.
    start_run(8'h0B, 4'd4, 4'd1, 3'd0);
    wait_done("basic");
    check("basic_done_at", done_at, 5 + PB);
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    check("basic_bits", vbits[4:0], 5'b10111);
`else
    check("basic_bits", vbits[3:0], 4'b1011);
`endif

    // Repeat with gap.
    start_run(8'h05, 4'd3, 4'd3, 3'd2);
    wait_done("gap");
    check("gap_done_at", done_at, 14 + 3 * PB);
    check("gap_nvalid", nvalid, 9 + 3 * PB);
`ifndef SEQ_PATTERN_GEN_PARITY_EN
    check("gap_bits", vbits[8:0], 9'b101101101);
`endif

    // Back-to-back full-length.
    start_run(8'hB4, 4'd8, 4'd2, 3'd0);
    wait_done("b2b");
    check("b2b_done_at", done_at, 17 + 2 * PB);
`ifndef SEQ_PATTERN_GEN_PARITY_EN
    check("b2b_bits", vbits[15:0], 16'hB4B4);
`endif

    // len=0 completes immediately.
    start_run(8'hFF, 4'd0, 4'd3, 3'd1);
    wait_done("len0");
    check("len0_done_at", done_at, 1);
    check("len0_nvalid", nvalid, 0);

    // len clamped to 8.
    start_run(8'hA5, 4'd12, 4'd1, 3'd0);
    wait_done("clamp");
    check("clamp_nvalid", nvalid, 8 + PB);
`ifndef SEQ_PATTERN_GEN_PARITY_EN
    check("clamp_bits", vbits[7:0], 8'hA5);
`endif

    // reps=0 behaves as one repetition.
    start_run(8'h06, 4'd3, 4'd0, 3'd3);
    wait_done("reps0");
    check("reps0_nvalid", nvalid, 3 + PB);

    // Abort during the 2nd bit.
    start_run(8'h0B, 4'd4, 4'd1, 3'd0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {30'b0, busy, out_valid}, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_no_done", {31'b0, done_seen}, 32'd0);

    // Abort and start together in IDLE: nothing starts.
    @(negedge clk);
    pattern = 8'hFF; len = 4'd4; reps = 4'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_start_idle", {31'b0, busy}, 32'd0);

    // start while busy is ignored; captured inputs are not disturbed.
    start_run(8'h05, 4'd3, 4'd3, 3'd2);
    repeat (3) @(negedge clk);
    pattern = 8'hFF; len = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    check("busy_start_done_at", done_at, 14 + 3 * PB);

    // start during DONE ignored, start the cycle after DONE accepted.
    start_run(8'h02, 4'd2, 4'd1, 3'd0);
    @(negedge clk);
    if (PB != 0) @(negedge clk);
    @(negedge clk);
    check("done_cycle", {31'b0, done}, 32'd1);
    pattern = 8'h0D; len = 4'd4; reps = 4'd1; gap = 3'd0; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("after_done");
    check("after_done_done_at", done_at, 5 + PB);
`ifndef SEQ_PATTERN_GEN_PARITY_EN
    check("after_done_bits", vbits[3:0], 4'b1101);
`endif

    // Asynchronous reset mid-shift.
    start_run(8'hB4, 4'd8, 4'd1, 3'd0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check("async_rst", {27'b0, out, out_valid, out_parity, busy, done}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    start_run(8'h0B, 4'd4, 4'd1, 3'd0);
    wait_done("post_rst");
    check("post_rst_done_at", done_at, 5 + PB);

`ifdef SEQ_PATTERN_GEN_PARITY_EN
    start_run(8'h0B, 4'd4, 4'd2, 3'd1);
    wait_done("parity");
    check("parity_done_at", done_at, 12);
    check("parity_bits", vbits[9:0], 10'b1011110111);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
